// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter_pkg
//  Description : Shared constants for the external-interrupt arbiter:
//                register word addresses and the "no interrupt" claim ID.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    // Register word addresses
    localparam int IRQ_ENABLE    = 8'h00;
    localparam int IRQ_PENDING   = 8'h01;
    localparam int IRQ_THRESH    = 8'h02;
    localparam int IRQ_CLAIM     = 8'h03;
    localparam int IRQ_PRIO_BASE = 8'h10;

    // Claim ID meaning "nothing to service"
    localparam int IRQ_ID_NONE   = 0;

endpackage : irq_arbiter_pkg
`default_nettype wire

// File: rtl/irq_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter_if
//  Description : Source lines, CSR-style register port and interrupt outputs
//                of the interrupt arbiter. master = core/EX side,
//                slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_arbiter_if #(
    parameter int N_SRC  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_SRC + 1)
) ();

    logic [N_SRC-1:0]  src_i;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              irq_o;
    logic [ID_W-1:0]   irq_id_o;

    modport master (
        output src_i, we, waddr, wdata, re, raddr,
        input  rdata, irq_o, irq_id_o
    );

    modport slave (
        input  src_i, we, waddr, wdata, re, raddr,
        output rdata, irq_o, irq_id_o
    );

endinterface : irq_arbiter_if
`default_nettype wire

// File: rtl/irq_arbiter_prio_tree.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_tree
//  Description : Combinational selector: among the flagged candidates, pick
//                the highest priority; equal priorities resolve to the lowest
//                index. Returns ID = index+1, or 0 when no candidate exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_tree #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(N_SRC + 1)
) (
    input  logic [N_SRC-1:0]             cand_i,
    input  logic [N_SRC-1:0][PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]              best_id_o,
    output logic [PRIO_W-1:0]            best_prio_o
);

    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;

    // Linear scan; strict '>' keeps the earliest index on a tie
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cand_i[i] && (prio_i[i] > best_prio)) begin
                best_id   = ID_W'(i + 1);
                best_prio = prio_i[i];
            end
        end
    end

    assign best_id_o   = best_id;
    assign best_prio_o = best_prio;

endmodule : irq_prio_tree
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : N_SRC-source external interrupt arbiter with per-source
//                enable/priority, edge or level gateways, global threshold
//                and a claim/complete handshake over a register port.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter int               PRIO_W    = 3,
    parameter logic [N_SRC-1:0] EDGE_MASK = N_SRC'(8'hFF),
    parameter int               ADDR_W    = 8,
    parameter int               DATA_W    = 32,
    parameter int               ID_W      = $clog2(N_SRC + 1)
) (
    input  logic         clk,
    input  logic         rst,
    irq_arbiter_if.slave bus
);

    logic [N_SRC-1:0]             src_q;
    logic [N_SRC-1:0]             enable_q, enable_d;
    logic [N_SRC-1:0]             pending_q, pending_d;
    logic [N_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [PRIO_W-1:0]            thresh_q, thresh_d;
    logic                         in_service_q, in_service_d;
    logic [ID_W-1:0]              in_service_id_q, in_service_id_d;
    logic [ID_W-1:0]              irq_id_q, irq_id_d;
    logic                         irq_q, irq_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;

    logic [N_SRC-1:0]  set_cond;
    logic [N_SRC-1:0]  cand;
    logic [N_SRC-1:0]  w1c_mask;
    logic [N_SRC-1:0]  claim_clr;
    logic              claim_ok;
    logic              complete_ok;
    logic [ID_W-1:0]   tree_id;
    logic [PRIO_W-1:0] tree_prio;

    // A claim needs an idle arbiter and a real candidate already shown to the core
    assign claim_ok    = bus.re && (bus.raddr == ADDR_W'(IRQ_CLAIM)) && !in_service_q
                         && (irq_id_q != ID_W'(IRQ_ID_NONE));
    assign complete_ok = bus.we && (bus.waddr == ADDR_W'(IRQ_CLAIM)) && in_service_q
                         && (bus.wdata[ID_W-1:0] == in_service_id_q);

    // Per-source gateways and candidate qualification
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_gateway
        localparam logic [ID_W-1:0] c_id = ID_W'(gi + 1);

        if (EDGE_MASK[gi]) begin : g_edge
            assign set_cond[gi] = bus.src_i[gi] & ~src_q[gi];
        end else begin : g_level
            // The claiming cycle counts as in service so a held level line
            // does not immediately re-pend the request being claimed.
            logic busy;
            assign busy = (in_service_q && (in_service_id_q == c_id))
                          || (claim_ok && (irq_id_q == c_id));
            assign set_cond[gi] = bus.src_i[gi] & ~busy;
        end

        assign claim_clr[gi] = claim_ok && (irq_id_q == c_id);
        assign cand[gi]      = pending_q[gi] && enable_q[gi] && (prio_q[gi] != '0)
                               && (prio_q[gi] > thresh_q);
    end

    irq_prio_tree #(
        .N_SRC  (N_SRC),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_prio_tree (
        .cand_i      (cand),
        .prio_i      (prio_q),
        .best_id_o   (tree_id),
        .best_prio_o (tree_prio)
    );

    // Configuration register writes and the pending W1C mask
    always_comb begin
        enable_d = enable_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        w1c_mask = '0;
        if (bus.we) begin
            if (bus.waddr == ADDR_W'(IRQ_ENABLE))  enable_d = bus.wdata[N_SRC-1:0];
            if (bus.waddr == ADDR_W'(IRQ_THRESH))  thresh_d = bus.wdata[PRIO_W-1:0];
            if (bus.waddr == ADDR_W'(IRQ_PENDING)) w1c_mask = bus.wdata[N_SRC-1:0];
            for (int i = 0; i < N_SRC; i++) begin
                if (bus.waddr == ADDR_W'(IRQ_PRIO_BASE + i)) prio_d[i] = bus.wdata[PRIO_W-1:0];
            end
        end
    end

    // Pending, service state and the registered interrupt outputs
    always_comb begin
        pending_d       = (pending_q & ~(claim_clr | w1c_mask)) | set_cond;
        in_service_d    = in_service_q;
        in_service_id_d = in_service_id_q;
        if (claim_ok) begin
            in_service_d    = 1'b1;
            in_service_id_d = irq_id_q;
        end else if (complete_ok) begin
            in_service_d    = 1'b0;
        end
        irq_id_d = tree_id;
        irq_d    = (tree_id != ID_W'(IRQ_ID_NONE)) && !in_service_d;
    end

    // Register read mux; unmapped addresses and unused bits read zero
    always_comb begin
        rdata_d = '0;
        if (bus.re) begin
            case (bus.raddr)
                ADDR_W'(IRQ_ENABLE):  rdata_d = DATA_W'(enable_q);
                ADDR_W'(IRQ_PENDING): rdata_d = DATA_W'(pending_q);
                ADDR_W'(IRQ_THRESH):  rdata_d = DATA_W'(thresh_q);
                ADDR_W'(IRQ_CLAIM):   rdata_d = claim_ok ? DATA_W'(irq_id_q) : '0;
                default: begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (bus.raddr == ADDR_W'(IRQ_PRIO_BASE + i)) rdata_d = DATA_W'(prio_q[i]);
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q           <= '0;
            enable_q        <= '0;
            pending_q       <= '0;
            prio_q          <= '0;
            thresh_q        <= '0;
            in_service_q    <= 1'b0;
            in_service_id_q <= '0;
            irq_id_q        <= '0;
            irq_q           <= 1'b0;
            rdata_q         <= '0;
        end else begin
            src_q           <= bus.src_i;
            enable_q        <= enable_d;
            pending_q       <= pending_d;
            prio_q          <= prio_d;
            thresh_q        <= thresh_d;
            in_service_q    <= in_service_d;
            in_service_id_q <= in_service_id_d;
            irq_id_q        <= irq_id_d;
            irq_q           <= irq_d;
            rdata_q         <= rdata_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.irq_o    = irq_q;
    assign bus.irq_id_o = irq_id_q;

    // Upper write-data bits and the winning priority have no consumer
    logic unused_ok;
    assign unused_ok = ^{bus.wdata, tree_prio};

endmodule : irq_arbiter
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_arbiter
//  Description : Directed scoreboard bench for irq_arbiter. Stimulus pushes
//                expected read data / interrupt state into queues; a monitor
//                on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        string name;
        logic  irq;
        int    id;     // negative = ID not checked
    } irq_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_arbiter_if #(.N_SRC(8), .ADDR_W(8), .DATA_W(32)) bus ();

    irq_arbiter #(
        .N_SRC     (8),
        .PRIO_W    (3),
        .EDGE_MASK (8'hF7),
        .ADDR_W    (8),
        .DATA_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    logic     rd_due   = 1'b0;

    // Monitor: read data is due the cycle after re; irq expectations sample now
    always @(negedge clk) begin
        rd_exp_t  re_e;
        irq_exp_t ie;
        if (rd_due) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                $display("FAIL unexpected_read: rdata=%0h with no expectation queued", bus.rdata);
            end else begin
                re_e = rd_q.pop_front();
                if (bus.rdata === re_e.val) n_pass++;
                else $display("FAIL %s: rdata=%0h expected %0h", re_e.name, bus.rdata, re_e.val);
            end
        end
        rd_due = bus.re;
        while (irq_q.size() > 0) begin
            ie = irq_q.pop_front();
            n_checks++;
            if ((bus.irq_o === ie.irq) && ((ie.id < 0) || (bus.irq_id_o === 4'(ie.id))))
                n_pass++;
            else
                $display("FAIL %s: irq_o=%0b irq_id_o=%0d expected irq_o=%0b irq_id_o=%0d",
                         ie.name, bus.irq_o, bus.irq_id_o, ie.irq, ie.id);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.waddr = 8'(a);
        bus.wdata = d;
        cyc();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] exp_v, input string nm);
        rd_exp_t e;
        e.name    = nm;
        e.val     = exp_v;
        rd_q.push_back(e);
        bus.re    = 1'b1;
        bus.raddr = 8'(a);
        cyc();
        bus.re    = 1'b0;
    endtask

    task automatic chk_irq(input string nm, input logic exp_irq, input int exp_id);
        irq_exp_t e;
        e.name = nm;
        e.irq  = exp_irq;
        e.id   = exp_id;
        irq_q.push_back(e);
    endtask

    task automatic pulse(input logic [7:0] m);
        bus.src_i = m;
        cyc();
        bus.src_i = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, 0 expected");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_i = '0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re = 1'b0; bus.raddr = '0;

        // Reset state
        repeat (2) cyc();
        chk_irq("reset_irq", 1'b0, 0);
        rd(IRQ_ENABLE, 32'h0, "reset_rdata");
        rst = 1'b0;
        cyc();
        rd(IRQ_ENABLE,  32'h0, "reset_enable");
        rd(IRQ_PENDING, 32'h0, "reset_pending");
        rd(IRQ_THRESH,  32'h0, "reset_thresh");

        // 1: edge detect and latency
        wr(IRQ_ENABLE, 32'h01);
        wr(IRQ_PRIO_BASE + 0, 32'd3);
        wr(IRQ_THRESH, 32'd0);
        pulse(8'h01);
        chk_irq("t1_not_yet", 1'b0, 0);
        cyc();
        chk_irq("t1_irq", 1'b1, 1);
        rd(IRQ_CLAIM, 32'd1, "t1_claim");
        chk_irq("t1_irq_drop", 1'b0, -1);
        rd(IRQ_PENDING, 32'h0, "t1_pending_clr");
        wr(IRQ_CLAIM, 32'd1);
        cyc();
        chk_irq("t1_idle", 1'b0, 0);

        // 2: priority and tie-break
        wr(IRQ_ENABLE, 32'h64);
        wr(IRQ_PRIO_BASE + 2, 32'd4);
        wr(IRQ_PRIO_BASE + 5, 32'd6);
        wr(IRQ_PRIO_BASE + 6, 32'd6);
        pulse(8'h64);
        cyc();
        chk_irq("t2_best", 1'b1, 6);
        rd(IRQ_CLAIM, 32'd6, "t2_claim6");
        wr(IRQ_CLAIM, 32'd6);
        rd(IRQ_CLAIM, 32'd7, "t2_claim7");
        wr(IRQ_CLAIM, 32'd7);
        rd(IRQ_CLAIM, 32'd3, "t2_claim3");
        wr(IRQ_CLAIM, 32'd3);
        cyc();
        chk_irq("t2_idle", 1'b0, 0);

        // 3: threshold
        wr(IRQ_ENABLE, 32'h02);
        wr(IRQ_PRIO_BASE + 1, 32'd2);
        wr(IRQ_THRESH, 32'd2);
        pulse(8'h02);
        cyc(); cyc();
        chk_irq("t3_blocked", 1'b0, 0);
        rd(IRQ_PENDING, 32'h02, "t3_pending");
        wr(IRQ_THRESH, 32'd1);
        chk_irq("t3_write_cycle", 1'b0, 0);
        cyc();
        chk_irq("t3_unblocked", 1'b1, 2);
        rd(IRQ_CLAIM, 32'd2, "t3_claim");
        wr(IRQ_CLAIM, 32'd2);
        wr(IRQ_THRESH, 32'd0);

        // 4: level source re-pend
        wr(IRQ_ENABLE, 32'h08);
        wr(IRQ_PRIO_BASE + 3, 32'd5);
        bus.src_i = 8'h08;
        cyc();
        chk_irq("t4_not_yet", 1'b0, 0);
        cyc();
        chk_irq("t4_irq", 1'b1, 4);
        rd(IRQ_CLAIM, 32'd4, "t4_claim");
        rd(IRQ_PENDING, 32'h0, "t4_masked");
        wr(IRQ_CLAIM, 32'd4);
        chk_irq("t4_after_complete", 1'b0, 0);
        cyc();
        rd(IRQ_PENDING, 32'h08, "t4_repend");
        chk_irq("t4_repend_irq", 1'b1, 4);
        bus.src_i = 8'h00;
        rd(IRQ_CLAIM, 32'd4, "t4_claim2");
        wr(IRQ_CLAIM, 32'd4);
        cyc(); cyc();
        rd(IRQ_PENDING, 32'h0, "t4_low_stays");
        chk_irq("t4_low_idle", 1'b0, 0);

        // 5: busy claim, wrong complete, coalescing
        wr(IRQ_ENABLE, 32'h01);
        pulse(8'h01);
        cyc();
        rd(IRQ_CLAIM, 32'd1, "t5_claim");
        rd(IRQ_CLAIM, 32'd0, "t5_busy_claim");
        wr(IRQ_CLAIM, 32'd2);
        pulse(8'h01);
        cyc();
        pulse(8'h01);
        cyc();
        rd(IRQ_PENDING, 32'h01, "t5_coalesced");
        chk_irq("t5_in_service", 1'b0, 1);
        rd(IRQ_CLAIM, 32'd0, "t5_still_busy");
        wr(IRQ_CLAIM, 32'd1);
        chk_irq("t5_reassert", 1'b1, 1);
        rd(IRQ_CLAIM, 32'd1, "t5_claim_again");
        wr(IRQ_CLAIM, 32'd1);
        rd(IRQ_PENDING, 32'h0, "t5_single_pend");

        // 6: reset mid service, then W1C/edge collision
        pulse(8'h01);
        cyc();
        rd(IRQ_CLAIM, 32'd1, "t6_claim");
        rst = 1'b1;
        rd(IRQ_ENABLE, 32'h0, "t6_rdata_in_rst");
        chk_irq("t6_irq_rst", 1'b0, 0);
        rst = 1'b0;
        cyc();
        rd(IRQ_ENABLE, 32'h0, "t6_enable_lost");
        rd(IRQ_PRIO_BASE + 0, 32'h0, "t6_prio_lost");
        wr(IRQ_ENABLE, 32'h01);
        wr(IRQ_PRIO_BASE + 0, 32'd3);
        pulse(8'h01);
        cyc();
        bus.src_i = 8'h01;
        bus.we    = 1'b1;
        bus.waddr = 8'(IRQ_PENDING);
        bus.wdata = 32'h01;
        cyc();
        bus.we    = 1'b0;
        bus.src_i = 8'h00;
        rd(IRQ_PENDING, 32'h01, "t6_set_wins");
        wr(IRQ_PENDING, 32'h01);
        rd(IRQ_PENDING, 32'h0, "t6_w1c");

        // Register map edges
        wr(IRQ_THRESH, 32'hFF);
        rd(IRQ_THRESH, 32'h07, "map_thresh_width");
        wr(8'h05, 32'hFFFF_FFFF);
        rd(8'h05, 32'h0, "map_unmapped");
        rd(IRQ_PRIO_BASE + 8, 32'h0, "map_prio_oob");
        rd(IRQ_PRIO_BASE + 0, 32'h3, "map_prio0");

        // Drain and account for anything never compared
        repeat (3) cyc();
        while (rd_q.size() > 0) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            n_checks++;
            $display("FAIL %s: no read response, expected %0h", e.name, e.val);
        end
        while (irq_q.size() > 0) begin
            irq_exp_t e;
            e = irq_q.pop_front();
            n_checks++;
            $display("FAIL %s: never sampled, expected irq_o=%0b", e.name, e.irq);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_irq_arbiter
`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Parametrised external-interrupt arbiter feeding the core's interrupt input (the single-bit interrupt line into CLINT).
- Generalises the fixed-width direct interrupt bus to N_SRC sources with:
  - per-source enable and priority,
  - per-source edge or level mode,
  - a global threshold,
  - a claim/complete handshake over a CSR-style register port driven from EX.
- Exactly one interrupt is in service at a time; no nesting.

Parameters:
- N_SRC, 8: number of interrupt sources (1..31).
- PRIO_W, 3: priority field width. Priority 0 means never interrupt.
- EDGE_MASK, 8'hFF: bit i = 1 makes source i edge-triggered (rising edge); 0 makes it level-triggered (active high).
- ADDR_W, 8: register port address width (word addresses).
- DATA_W, 32: register port data width.
- ID_W, $clog2(N_SRC+1): claim ID width. ID 0 = none; source i has ID i+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- src_i  in  N_SRC  raw interrupt sources, already synchronous to clk
- we  in  1  register write strobe
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re  in  1  register read strobe; a read of CLAIM performs the claim side effect
- raddr  in  ADDR_W  read address
- rdata  out  DATA_W  read data, registered, valid the cycle after re
- irq_o  out  1  interrupt request to core
- irq_id_o  out  ID_W  ID of the current best candidate, 0 if none

Behaviour:
- Reset: rdata=0, irq_o=0, irq_id_o=0. The following registers also clear to 0: enable, pending, priorities, threshold, in_service, in_service_id, src_q.

Register map (word addresses):
- 0x00 ENABLE: RW, bits[N_SRC-1:0].
- 0x01 PENDING: reads pending. Write-1-to-clear.
- 0x02 THRESHOLD: RW, bits[PRIO_W-1:0].
- 0x03 CLAIM/COMPLETE:
  - Read = claim: returns an ID.
  - Write = complete: wdata[ID_W-1:0] is the ID being completed.
- 0x10+i PRIO[i]: RW, bits[PRIO_W-1:0].
- Unmapped addresses read 0; writes to them are ignored.
- Unused upper bits read 0.

Gateway, per source:
- src_q is src_i registered.
- Edge mode: the set condition is src_i & ~src_q.
- Level mode: the set condition is src_i & ~(in_service && in_service_id == i+1).
- pending[i] is set on the set condition. Set takes priority over a same-cycle claim-clear or W1C for that bit.
- An edge arriving while source i is in service latches pending (one deep); further edges coalesce into it.

Arbitration:
- Candidates are sources with pending & enable, prio[i] != 0 and prio[i] > threshold.
- Highest priority wins; a tie goes to the lowest index.
- The winning ID and priority are registered into irq_id_o.
- irq_o = (irq_id_o != 0) & ~in_service, registered together with irq_id_o.

Latency:
- A source edge sampled at clock T sets pending at T.
- irq_id_o and irq_o update at T+1.
- Enable, priority and threshold writes take effect on irq_o one cycle after the write cycle.

Claim (re with raddr=0x03):
- If ~in_service and irq_id_o != 0:
  - rdata = irq_id_o next cycle.
  - That source's pending bit clears.
  - in_service is set and in_service_id = irq_id_o.
  - irq_o drops on the next edge.
- Otherwise rdata = 0 and no state changes.
- The claim uses the registered irq_id_o, so the ID returned always equals the ID the core saw.

Complete (we with waddr=0x03):
- If in_service and wdata matches in_service_id: in_service clears.
- Otherwise the write is ignored.
- A level source still high re-pends on the cycle after complete.

Simultaneous events:
- A same-cycle claim and complete are both evaluated against the pre-cycle state.
- Claim while busy returns 0, so only the complete takes effect.

Reset mid-operation:
- In-service state, pending and configuration are all lost.
- The core must re-program the block after reset.

Decomposition:
- Shared para header gains:
  - IRQ register address constants (IRQ_ENABLE, IRQ_PENDING, IRQ_THRESH, IRQ_CLAIM, IRQ_PRIO_BASE),
  - IRQ_ID_NONE.
- One sub-module, irq_prio_tree: a combinational max-priority/lowest-index selector over N_SRC entries, parametrised by N_SRC and PRIO_W.
- Gateways, registers and the claim logic stay in irq_arbiter.

Test Plan:
1. Edge detect and latency:
   - Stimulus: ENABLE=0x01, PRIO[0]=3, THRESHOLD=0; pulse src_i[0] one cycle.
   - Response: irq_o=1 and irq_id_o=1 exactly 1 cycle after the pulse is sampled; claim read returns 1; irq_o=0 next cycle; PENDING=0.
2. Priority and tie-break:
   - Stimulus: sources 2, 5, 6 pending with PRIO 4, 6, 6.
   - Response: claim returns 6 (source 5). After complete(6), claim returns 7, then 3.
3. Threshold:
   - Stimulus: PRIO[1]=2, THRESHOLD=2, source 1 pending.
   - Response: irq_o stays 0. After writing THRESHOLD=1, irq_o=1 one cycle after the write.
4. Level re-pend:
   - Stimulus: EDGE_MASK bit3=0, src_i[3] held high; claim returns 4; complete(4).
   - Response: pending[3] is set again the cycle after complete and irq_o reasserts. With src_i[3] low, it stays 0.
5. Busy, wrong complete, and coalescing:
   - Stimulus: while ID 1 is in service, a second claim is made, complete(2) is written, and two edges arrive on source 0.
   - Response: the second claim returns 0; complete(2) is ignored (in_service stays 1); the two edges leave pending[0]=1 (coalesced).
6. Reset and collision:
   - Stimulus: assert rst mid in-service.
   - Response: all outputs are 0 next cycle and ENABLE reads 0.
   - Stimulus: a W1C on PENDING bit0 in the same cycle as a new edge on source 0.
   - Response: pending[0] stays 1.
